// File: rtl/pcs_tx_pkg.sv
// pcs_tx_pkg: shared header codes and gearbox sizing helpers for the 64b/66b TX path
package pcs_tx_pkg;
  localparam logic [1:0] HEAD_DATA = 2'b01;
  localparam logic [1:0] HEAD_CTRL = 2'b10;
  function automatic int seq_full(input int data_w, input int head_w);
    return data_w / head_w;
  endfunction
  function automatic int cnt_n(input int block_data_w, input int data_w);
    return block_data_w / data_w;
  endfunction
endpackage

// File: rtl/gearbox_tx_seq_cnt.sv
// gearbox_tx_seq_cnt: gearbox sequence and intra-block word counters with the stall slot
module gearbox_tx_seq_cnt #(
  parameter int SEQ_FULL = 32,
  parameter int SEQ_W = 6,
  parameter int CNT_N = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [SEQ_W-1:0] seq,
  output logic             stall,
  output logic             blk_start
);
  logic last;
  assign stall = seq == SEQ_W'(SEQ_FULL);
  always_ff @(posedge clk or posedge rst)
    if (rst) seq <= '0;
    else if (en) seq <= stall ? '0 : last ? seq + SEQ_W'(1) : seq;
  if (CNT_N > 1) begin : g_wcnt
    localparam int W = $clog2(CNT_N);
    logic [W-1:0] wcnt;
    always_ff @(posedge clk or posedge rst)
      if (rst) wcnt <= '0;
      else if (en & ~stall) wcnt <= last ? '0 : wcnt + W'(1);
    assign last = wcnt == W'(CNT_N - 1);
    assign blk_start = wcnt == '0;
  end else begin : g_single
    assign last = 1'b1;
    assign blk_start = 1'b1;
  end
endmodule

// File: rtl/gearbox_tx_ctrl.sv
// gearbox_tx_ctrl: TX gearbox sequencer aligning head/data/seq and flagging underflow/desync
module gearbox_tx_ctrl
  import pcs_tx_pkg::*;
#(
  parameter int BLOCK_DATA_W = 64,
  parameter int DATA_W = 64,
  parameter int HEAD_W = 2,
  parameter int SEQ_FULL = seq_full(DATA_W, HEAD_W),
  parameter int SEQ_W = $clog2(DATA_W / HEAD_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              in_valid_i,
  input  logic [HEAD_W-1:0] in_head_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_o,
  output logic [SEQ_W-1:0]  gb_seq_o,
  output logic [HEAD_W-1:0] gb_head_o,
  output logic [DATA_W-1:0] gb_data_o,
  input  logic              gb_full_v_i,
  output logic              blk_start_o,
  output logic              err_underflow_o,
  output logic              err_desync_o
);
  localparam int CNT_N = cnt_n(BLOCK_DATA_W, DATA_W);
  logic [SEQ_W-1:0] seq;
  logic stall, first, slot;
  gearbox_tx_seq_cnt #(.SEQ_FULL(SEQ_FULL), .SEQ_W(SEQ_W), .CNT_N(CNT_N)) u_cnt (
    .clk(clk),
    .rst(rst),
    .en(en_i),
    .seq(seq),
    .stall(stall),
    .blk_start(first)
  );
  assign slot = en_i & ~stall;
  assign in_ready_o = slot & ~rst;
  // a missing word still consumes its slot so the gearbox cadence never slips
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      gb_seq_o <= '0;
      gb_head_o <= '0;
      gb_data_o <= '0;
      blk_start_o <= 1'b0;
      err_underflow_o <= 1'b0;
      err_desync_o <= 1'b0;
    end else begin
      if (en_i) begin
        gb_seq_o <= seq;
        blk_start_o <= slot & first;
      end
      if (slot) begin
        gb_data_o <= in_valid_i ? in_data_i : '0;
        gb_head_o <= !in_valid_i ? '0 : first ? in_head_i : gb_head_o;
      end
      if (slot & ~in_valid_i) err_underflow_o <= 1'b1;
      if (gb_full_v_i != (gb_seq_o == SEQ_W'(SEQ_FULL))) err_desync_o <= 1'b1;
    end
endmodule
